// File: rtl/mci_line_serializer_pkg.sv
// Shared memory-controller interface types plus the beat/line parameters used by
// the line serializer that splits 128-bit cache lines into narrow memory beats.
package mci_line_serializer_pkg;

  localparam int MCI_ADDR_LENGTH  = 32;
  localparam int MCI_DATA_LENGTH  = 128;
  localparam int MCI_BEAT_WIDTH   = 32;
  localparam int MCI_BEATS        = MCI_DATA_LENGTH / MCI_BEAT_WIDTH;
  localparam int MCI_LINE_BYTES   = 16;
  localparam int MCI_BEAT_IDX_W   = $clog2(MCI_BEATS);

  typedef logic [MCI_ADDR_LENGTH-1:0] mci_addr_t;
  typedef logic [MCI_DATA_LENGTH-1:0] mci_data_t;
  typedef logic [MCI_BEAT_WIDTH-1:0]  mci_beat_t;
  typedef logic [MCI_BEAT_IDX_W-1:0]  mci_beat_idx_t;

  typedef struct packed {
    mci_addr_t addr;
    mci_data_t data;
    logic      rw;
    logic      valid;
  } mci_request_t;

  typedef struct packed {
    mci_data_t data;
    logic      ready;
  } mci_response_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } mci_ser_state_t;

  localparam mci_addr_t MCI_LINE_MASK = ~mci_addr_t'(MCI_LINE_BYTES - 1);

  // Lines are aligned, so the low offset bits of a request address are dropped.
  function automatic mci_addr_t mci_line_base(mci_addr_t addr);
    return addr & MCI_LINE_MASK;
  endfunction

  function automatic mci_addr_t mci_beat_addr(mci_addr_t base, mci_beat_idx_t idx, int stride);
    return base + (mci_addr_t'(idx) * mci_addr_t'(stride));
  endfunction

endpackage

// File: rtl/mci_line_serializer_if.sv
// Bundle of the cache-side line handshake and the narrow memory beat bus.
interface mci_line_serializer_if;
  import mci_line_serializer_pkg::*;

  mci_request_t  req;
  mci_response_t resp;
  logic          mem_req;
  logic          mem_we;
  mci_addr_t     mem_addr;
  mci_beat_t     mem_wdata;
  logic          mem_ack;
  mci_beat_t     mem_rdata;

  modport slave (
    input  req,
    input  mem_ack,
    input  mem_rdata,
    output resp,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output req,
    output mem_ack,
    output mem_rdata,
    input  resp,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/mci_line_serializer.sv
// Line serializer: accepts one cache-line request, moves it as BEATS ascending beats
// over the req/ack memory bus, then returns the line with a one-cycle ready pulse.
module mci_line_serializer
  import mci_line_serializer_pkg::*;
#(
  parameter int BEAT_WIDTH = MCI_BEAT_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  mci_line_serializer_if.slave bus
);

  localparam int BEATS       = MCI_DATA_LENGTH / BEAT_WIDTH;
  localparam int BYTE_STRIDE = BEAT_WIDTH / 8;
  localparam int LSB_W       = $clog2(MCI_DATA_LENGTH);
  localparam mci_beat_idx_t LAST_BEAT = mci_beat_idx_t'(BEATS - 1);

  function automatic logic [LSB_W-1:0] beat_lsb(mci_beat_idx_t idx);
    return LSB_W'(idx) * LSB_W'(BEAT_WIDTH);
  endfunction

  mci_ser_state_t state_r, state_s;
  mci_beat_idx_t  beat_r, beat_s;
  mci_addr_t      base_r, base_s;
  logic           rw_r, rw_s;
  mci_data_t      line_r, line_s;
  logic           mem_req_r, mem_req_s;
  logic           mem_we_r, mem_we_s;
  mci_addr_t      mem_addr_r, mem_addr_s;
  mci_beat_t      mem_wdata_r, mem_wdata_s;
  logic           ready_r, ready_s;
  mci_data_t      resp_data_r, resp_data_s;

  // Next-state and next-output logic; every output is presented from a flop.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    base_s      = base_r;
    rw_s        = rw_r;
    line_s      = line_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    ready_s     = 1'b0;
    resp_data_s = resp_data_r;

    case (state_r)
      IDLE: begin
        if (bus.req.valid) begin
          base_s = mci_line_base(bus.req.addr);
          rw_s   = bus.req.rw;
          if (bus.req.rw) begin
            line_s = bus.req.data;
          end else begin
            line_s = line_r;
          end
          beat_s      = '0;
          mem_req_s   = 1'b1;
          mem_we_s    = bus.req.rw;
          mem_addr_s  = base_s;
          mem_wdata_s = line_s[BEAT_WIDTH-1:0];
          state_s     = BEAT;
        end else begin
          mem_req_s = 1'b0;
        end
      end

      BEAT: begin
        if (bus.mem_ack) begin
          if (!rw_r) begin
            line_s[beat_lsb(beat_r) +: BEAT_WIDTH] = bus.mem_rdata;
          end else begin
            line_s = line_r;
          end
          // The completed line goes straight into the response register so ready and data align.
          if (beat_r == LAST_BEAT) begin
            mem_req_s   = 1'b0;
            ready_s     = 1'b1;
            resp_data_s = line_s;
            state_s     = RESP;
          end else begin
            beat_s      = beat_r + mci_beat_idx_t'(1);
            mem_addr_s  = mci_beat_addr(base_r, beat_s, BYTE_STRIDE);
            mem_wdata_s = line_s[beat_lsb(beat_s) +: BEAT_WIDTH];
          end
        end else begin
          state_s = BEAT;
        end
      end

      RESP: begin
        state_s = IDLE;
      end

      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_r      <= '0;
      base_r      <= '0;
      rw_r        <= 1'b0;
      line_r      <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      ready_r     <= 1'b0;
      resp_data_r <= '0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      base_r      <= base_s;
      rw_r        <= rw_s;
      line_r      <= line_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      ready_r     <= ready_s;
      resp_data_r <= resp_data_s;
    end
  end

  assign bus.resp.data  = resp_data_r;
  assign bus.resp.ready = ready_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_mci_line_serializer.sv
// Directed and randomized bench for mci_line_serializer against a line-level memory model.
module tb_mci_line_serializer;
  import mci_line_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [127:0] last_line = 128'h0;
  logic [31:0]  rd_preset[$];

  mci_line_serializer_if bus ();

  mci_line_serializer #(.BEAT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One line transfer; the memory acks each beat after 'stall' wait cycles.
  task automatic do_txn(input logic [31:0] addr, input logic [127:0] data, input logic rw,
                        input int stall, input int abort_at, input bit toggle);
    logic [31:0]  base;
    logic [127:0] exp_line;
    logic [31:0]  rd;
    int acks, waitc;
    bit got_ready;
    base = addr & 32'hFFFF_FFF0;
    exp_line = rw ? data : 128'h0;
    acks = 0; waitc = 0; got_ready = 1'b0;
    bus.req.addr = addr; bus.req.data = data; bus.req.rw = rw; bus.req.valid = 1'b1;
    bus.mem_ack = 1'b0;
    for (int cyc = 2; cyc < 300 && !got_ready; cyc++) begin
      @(posedge clk); #1;
      if (bus.resp.ready) begin
        got_ready = 1'b1;
        bus.mem_ack = 1'b0;
        chk("latency", 128'(cyc), 128'(4 * (stall + 1) + 2));
        chk("beats_done", 128'(acks), 128'd4);
        chk("resp_data", bus.resp.data, exp_line);
        chk("req_low_in_resp", 128'(bus.mem_req), 128'd0);
      end else if (bus.mem_req) begin
        if (acks >= 4) begin
          chk("extra_beat", 128'(acks), 128'd3);
          bus.mem_ack = 1'b0;
        end else begin
          chk("mem_addr", 128'(bus.mem_addr), 128'(32'(base + 32'(4 * acks))));
          chk("mem_we", 128'(bus.mem_we), 128'(rw));
          if (rw) chk("mem_wdata", 128'(bus.mem_wdata), 128'(data[32*acks +: 32]));
          if (toggle) begin
            bus.req.valid = ~bus.req.valid;
            bus.req.addr  = $urandom;
          end
          if (abort_at == acks) begin
            rst = 1'b1;
            #1;
            chk("abort_mem_req", 128'(bus.mem_req), 128'd0);
            chk("abort_ready", 128'(bus.resp.ready), 128'd0);
            chk("abort_addr", 128'(bus.mem_addr), 128'd0);
            bus.mem_ack = 1'b0;
            bus.req.valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            last_line = 128'h0;
            return;
          end
          if (waitc == stall) begin
            if (rd_preset.size() > 0) rd = rd_preset.pop_front();
            else rd = $urandom;
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rd;
            if (!rw) exp_line[32*acks +: 32] = rd;
            acks++;
            waitc = 0;
          end else begin
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
            waitc++;
          end
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
    if (!got_ready) chk("ready_timeout", 128'(got_ready), 128'd1);
    else last_line = exp_line;
    @(posedge clk); #1;
    bus.req.valid = 1'b0;
    bus.mem_ack = 1'b0;
    chk("ready_pulse", 128'(bus.resp.ready), 128'd0);
    chk("resp_hold", bus.resp.data, last_line);
  endtask

  // Idle cycles, optionally with stray acks, expecting no activity at all.
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      bus.req.valid = 1'b0;
      bus.mem_ack = stray;
      bus.mem_rdata = $urandom;
      @(posedge clk); #1;
      chk("idle_req", 128'(bus.mem_req), 128'd0);
      chk("idle_ready", 128'(bus.resp.ready), 128'd0);
      chk("idle_data", bus.resp.data, last_line);
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 128'(bus.mem_req), 128'd0);
    chk("rst_mem_we", 128'(bus.mem_we), 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", 128'(bus.mem_wdata), 128'd0);
    chk("rst_ready", 128'(bus.resp.ready), 128'd0);
    chk("rst_data", bus.resp.data, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read with immediate acks and fixed memory words
    rd_preset = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_txn(32'h0000_1008, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, -1, 1'b0);
    chk("read_line_packed", last_line, 128'h00000044_00000033_00000022_00000011);

    idle_cycles(3, 1'b1);

    // Write with immediate acks
    do_txn(32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, 0, -1, 1'b0);

    // Stalled read and write
    do_txn(32'h0000_3004, 128'h0, 1'b0, 3, -1, 1'b0);
    do_txn(32'hFFFF_FFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 3, -1, 1'b0);

    // Back-to-back: the write arrives the cycle after the read's ready
    do_txn(32'h0000_4000, 128'h0, 1'b0, 0, -1, 1'b0);
    do_txn(32'h0000_5010, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, -1, 1'b0);

    // valid toggled and address disturbed during BEAT
    do_txn(32'h0000_6000, 128'h0, 1'b0, 2, -1, 1'b1);
    idle_cycles(2, 1'b1);

    // Reset during beat 2 of a read, then a clean restart
    do_txn(32'h0000_7000, 128'h0, 1'b0, 1, 2, 1'b0);
    @(posedge clk); #1;
    chk("post_abort_data", bus.resp.data, 128'h0);
    chk("post_abort_ready", 128'(bus.resp.ready), 128'd0);
    do_txn(32'h0000_7000, 128'h0, 1'b0, 0, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      do_txn($urandom, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)),
             int'($urandom_range(2, 0)), -1, 1'b0);
      if (t % 3 == 2) idle_cycles(1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
